// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding and instruction-memory constants for the boot loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE, ERR} state_e;
  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_IDX_W = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/imem_word_asm.sv
// imem_word_asm: big-endian byte-to-word shifter; word_o includes the byte presented this cycle
module imem_word_asm (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clr_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);
  logic [23:0] asm_q;
  logic [1:0]  idx_q;
  assign word_o       = {asm_q, byte_i};
  assign word_ready_o = valid_i && idx_q == 2'd3;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      asm_q <= '0;
      idx_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (valid_i) begin
      asm_q <= {asm_q[15:0], byte_i};
      idx_q <= idx_q + 1'b1;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time UART byte stream to instruction RAM writer that holds the CPU while loading
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH   = IMEM_DEPTH,
  parameter int TIMEOUT = 1000000,
  parameter int TO_W    = 20
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_req_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        imem_we_o,
  output logic        cpu_hold_o,
  output logic        load_done_o,
  output logic        load_err_o
);
  state_e                state_q;
  logic [15:0]           n_q;
  logic [IMEM_IDX_W-1:0] widx_q;
  logic [TO_W-1:0]       to_q;
  logic [31:0]           addr_q, wdata_q, word;
  logic                  we_q, hold_q, done_q, err_q;
  logic                  acc, word_ready, timed_out;
  logic [15:0]           n_full;
  assign rx_ready_o   = state_q inside {CNT_HI, CNT_LO, DATA};
  assign acc          = rx_valid_i && rx_ready_o;
  assign timed_out    = rx_ready_o && !acc && to_q == TO_W'(TIMEOUT - 1);
  assign n_full       = {n_q[15:8], rx_data_i};
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign imem_we_o    = we_q;
  assign cpu_hold_o   = hold_q;
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;
  imem_word_asm u_asm (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clr_i       (state_q == CNT_LO),
    .valid_i     (acc && state_q == DATA),
    .byte_i      (rx_data_i),
    .word_o      (word),
    .word_ready_o(word_ready)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      n_q     <= '0;
      widx_q  <= '0;
      to_q    <= '0;
      addr_q  <= RESET_PC;
      wdata_q <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (rx_ready_o) to_q <= acc ? '0 : to_q + 1'b1;
      case (state_q)
        IDLE: if (load_req_i) begin
          hold_q  <= 1'b1;
          err_q   <= 1'b0;
          to_q    <= '0;
          state_q <= CNT_HI;
        end
        CNT_HI: if (acc) begin
          n_q[15:8] <= rx_data_i;
          state_q   <= CNT_LO;
        end
        CNT_LO: if (acc) begin
          n_q[7:0] <= rx_data_i;
          widx_q   <= '0;
          if (n_full == 16'd0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (n_full > 16'(DEPTH)) begin
            err_q   <= 1'b1;
            state_q <= ERR;
          end else state_q <= DATA;
        end
        DATA: if (word_ready) begin
          we_q    <= 1'b1;
          addr_q  <= 32'({widx_q, 2'b00});
          wdata_q <= word;
          state_q <= WRITE;
        end
        WRITE: if (16'(widx_q) == n_q - 16'd1) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          widx_q  <= widx_q + 1'b1;
          state_q <= DATA;
        end
        DONE, ERR: begin
          hold_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (timed_out) begin
        err_q   <= 1'b1;
        state_q <= ERR;
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: stream-level model plus directed vectors for the instruction memory loader
module tb_imem_loader;
  localparam int TO = 40;
  localparam int DEPTH = 256;
  logic clk = 1'b0, reset = 1'b1, load_req = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, imem_we, cpu_hold, load_done, load_err;
  logic [31:0] imem_addr, imem_wdata;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [63:0] wlog[$];
  logic [7:0] bq[$];
  bit e_ready, e_we, e_hold, e_done, e_err, fin;
  bit acc, n_ready, n_we, n_hold, n_done, n_err, n_fin;
  logic [31:0] e_addr, e_data;
  int idle, wr, nw, b;

  imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TO), .TO_W(6)) dut (
    .clk_i(clk), .reset_i(reset), .load_req_i(load_req), .rx_data_i(rx_data),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .imem_we_o(imem_we), .cpu_hold_o(cpu_hold),
    .load_done_o(load_done), .load_err_o(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for each cycle come from the accepted byte stream:
  // byte count, word count N and idle-cycle tally since the last byte.
  always @(negedge clk) begin
    if (reset) begin
      {e_ready, e_we, e_hold, e_done, e_err, fin} = '0;
      bq.delete();
      idle = 0; wr = 0; nw = 0;
    end else begin
      chk("rx_ready", 32'(rx_ready), 32'(e_ready));
      chk("imem_we", 32'(imem_we), 32'(e_we));
      chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
      chk("load_done", 32'(load_done), 32'(e_done));
      chk("load_err", 32'(load_err), 32'(e_err));
      if (e_we) begin
        chk("imem_addr", imem_addr, e_addr);
        chk("imem_wdata", imem_wdata, e_data);
      end
      if (imem_we) wlog.push_back({imem_addr, imem_wdata});
      if (load_done) done_cnt++;
      acc = rx_valid && e_ready;
      n_ready = e_ready; n_hold = e_hold; n_err = e_err;
      n_we = 0; n_done = 0; n_fin = 0;
      if (fin) begin
        n_hold = 0;
      end else if (!e_hold) begin
        if (load_req) begin
          n_hold = 1; n_err = 0; n_ready = 1;
          bq.delete(); idle = 0; wr = 0;
        end
      end else if (e_we) begin
        if (wr == nw) begin n_done = 1; n_fin = 1; end
        else n_ready = 1;
      end else if (e_ready) begin
        if (acc) begin
          idle = 0;
          bq.push_back(rx_data);
          if (bq.size() == 2) begin
            nw = int'({bq[0], bq[1]});
            if (nw == 0) begin n_done = 1; n_fin = 1; n_ready = 0; end
            else if (nw > DEPTH) begin n_err = 1; n_fin = 1; n_ready = 0; end
          end else if (bq.size() > 2 && (bq.size() - 2) % 4 == 0) begin
            b = bq.size() - 4;
            wr = (bq.size() - 2) / 4;
            e_addr = 32'((wr - 1) * 4);
            e_data = {bq[b], bq[b+1], bq[b+2], bq[b+3]};
            n_we = 1; n_ready = 0;
          end
        end else begin
          idle++;
          if (idle == TO) begin n_err = 1; n_fin = 1; n_ready = 0; end
        end
      end
      e_ready = n_ready; e_we = n_we; e_hold = n_hold;
      e_done = n_done; e_err = n_err; fin = n_fin;
    end
  end

  task automatic pulse_req();
    load_req = 1;
    @(posedge clk); #1 load_req = 0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    int n = 0;
    rx_valid = 1; rx_data = v;
    @(negedge clk);
    while (!rx_ready && n < 100) begin @(negedge clk); n++; end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL send_byte: rx_ready stayed 0, expected 1");
    end
    @(posedge clk); #1 rx_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (cpu_hold && n < 200) begin @(negedge clk); n++; end
    if (cpu_hold) begin
      checks++; errors++;
      $display("FAIL wait_idle: cpu_hold stuck at 1, expected 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
    chk({tag, "_we"}, 32'(imem_we), 0);
    chk({tag, "_hold"}, 32'(cpu_hold), 0);
    chk({tag, "_done"}, 32'(load_done), 0);
    chk({tag, "_err"}, 32'(load_err), 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
  endtask

  initial begin
    logic [7:0] w3[12] = '{8'h20, 8'h04, 8'h30, 8'h39, 8'h24, 8'h05, 8'hd4, 8'h31,
                           8'h00, 8'h05, 8'h34, 8'h00};
    logic [7:0] seq[7] = '{8'h00, 8'h01, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee};
    int cnt, idx;
    bit a;
    #1 chk_reset_outs("reset0");
    @(posedge clk); @(posedge clk); #1 reset = 0;

    pulse_req();
    send_byte(8'h00); send_byte(8'h03);
    foreach (w3[i]) send_byte(w3[i]);
    wait_idle();
    chk("n3_writes", 32'(wlog.size()), 3);
    if (wlog.size() == 3) begin
      chk("n3_w0", wlog[0][31:0], 32'h20043039);
      chk("n3_a1", wlog[1][63:32], 32'h4);
      chk("n3_w1", wlog[1][31:0], 32'h2405d431);
      chk("n3_a2", wlog[2][63:32], 32'h8);
      chk("n3_w2", wlog[2][31:0], 32'h00053400);
    end
    chk("n3_done_cnt", 32'(done_cnt), 1);
    chk("n3_hold", 32'(cpu_hold), 0);

    wlog.delete();
    pulse_req();
    send_byte(8'h00); send_byte(8'h00);
    wait_idle();
    chk("n0_writes", 32'(wlog.size()), 0);
    chk("n0_done_cnt", 32'(done_cnt), 2);
    chk("n0_err", 32'(load_err), 0);

    pulse_req();
    send_byte(8'h01); send_byte(8'h01);
    wait_idle();
    chk("n257_writes", 32'(wlog.size()), 0);
    chk("n257_err", 32'(load_err), 1);
    chk("n257_hold", 32'(cpu_hold), 0);
    pulse_req();
    chk("n257_err_cleared", 32'(load_err), 0);
    send_byte(8'h00); send_byte(8'h00);
    wait_idle();

    wlog.delete();
    pulse_req();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    wait_idle();
    chk("to_writes", 32'(wlog.size()), 1);
    if (wlog.size() == 1) chk("to_w0", wlog[0][31:0], 32'h11223344);
    chk("to_err", 32'(load_err), 1);

    wlog.delete();
    pulse_req();
    cnt = 0; idx = 0;
    rx_valid = 1; rx_data = seq[0];
    repeat (30) begin
      @(negedge clk); a = rx_ready;
      @(posedge clk); #1;
      if (a) begin
        cnt++;
        if (idx < 6) idx++;
        rx_data = seq[idx];
      end
    end
    chk("stream_consumed", 32'(cnt), 6);
    chk("stream_7th_ready", 32'(rx_ready), 0);
    chk("stream_writes", 32'(wlog.size()), 1);
    if (wlog.size() == 1) chk("stream_w0", wlog[0][31:0], 32'haabbccdd);
    rx_valid = 0;

    wlog.delete();
    pulse_req();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h08); send_byte(8'h00);
    #3 reset = 1;
    #2 chk_reset_outs("reset_mid");
    @(posedge clk); @(posedge clk); #1 reset = 0;
    chk("post_reset_writes", 32'(wlog.size()), 0);
    pulse_req();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0b);
    wait_idle();
    chk("clean_writes", 32'(wlog.size()), 1);
    if (wlog.size() == 1) begin
      chk("clean_a0", wlog[0][63:32], 32'h0);
      chk("clean_w0", wlog[0][31:0], 32'h0800000b);
    end
    chk("clean_err", 32'(load_err), 0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the pipeline's instruction memory, which the fetch stage reads combinationally on word-aligned addr[9:2].
- Takes a byte stream from the UART RX path over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into instruction RAM.
- Holds the CPU in stall while loading, then releases it with PC restart at 0.

Parameters:
- DEPTH, 256, instruction memory depth in words; index is addr[9:2].
- TIMEOUT, 1000000, max idle cycles between bytes once a load has started.
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- load_req  input  1  one-cycle pulse that starts a load; ignored unless the FSM is in IDLE
- rx_data  input  8  received byte
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  loader accepts the byte this cycle
- imem_addr  output  32  byte address to instruction RAM; word-aligned, imem_addr[1:0] = 0
- imem_wdata  output  32  word to write
- imem_we  output  1  write strobe, one cycle per word
- cpu_hold  output  1  stalls the CPU and forces PC to 0 while high
- load_done  output  1  one-cycle pulse on successful completion
- load_err  output  1  sticky error flag; cleared by the next load_req or by reset

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE. Reset mid-load aborts immediately; RAM contents already written are kept.
- Byte handshake: a byte is consumed on a cycle where rx_valid && rx_ready. rx_ready = 1 only in CNT_HI, CNT_LO and DATA.
- Stream format:
  - 16-bit word count N, big-endian (high byte first).
  - Then N*4 data bytes, each word sent MSB first.
- FSM states:
  - IDLE: on load_req, set cpu_hold = 1, clear load_err and the timeout counter, go to CNT_HI.
  - CNT_HI: on a byte, latch N[15:8] and go to CNT_LO.
  - CNT_LO: on a byte, latch N[7:0].
    - N == 0: go to DONE.
    - N > DEPTH: go to ERR.
    - Otherwise: clear word index and byte index, go to DATA.
  - DATA: on a byte, shift it into the assembly register ({asm[23:0], byte}) and increment the 2-bit byte index. On the 4th byte, go to WRITE.
  - WRITE: one cycle.
    - imem_we = 1, imem_addr = {22'b0, word_idx, 2'b00}, imem_wdata = the assembled word.
    - If word_idx == N-1, go to DONE; otherwise increment word_idx and go to DATA.
    - rx_ready = 0 in this state, so no byte is lost.
  - DONE: one cycle. load_done = 1, cpu_hold drops to 0 on the next cycle, go to IDLE.
  - ERR: one cycle. load_err = 1 (sticky), cpu_hold drops to 0 on the next cycle, go to IDLE.
- Timeout:
  - In CNT_HI, CNT_LO and DATA, the counter increments every cycle with no accepted byte and clears on every accepted byte.
  - Reaching TIMEOUT goes to ERR.
  - A byte accepted in the same cycle the counter reaches TIMEOUT wins: the byte is accepted and the counter clears.
- load_req outside IDLE is ignored, with no restart.
- imem_we is never asserted outside WRITE. imem_addr and imem_wdata are registered and hold their last value otherwise.
- Latency: the write strobe comes 1 cycle after the 4th byte of each word is accepted. load_done comes 1 cycle after the final write.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE, ERR.
  - IMEM_DEPTH = 256, IMEM_IDX_W = 8.
  - Reset PC constant = 32'h0000_0000.
- One natural sub-module: imem_word_asm. It is the byte shifter plus 2-bit byte counter, with outputs word and word_ready.

Test Plan:
- load_req, then N=3 and bytes for 32'h20043039, 32'h2405d431, 32'h00053400 -> three imem_we pulses at addr 0x0, 0x4, 0x8 with those words; load_done 1 cycle after the last write; cpu_hold low afterwards.
- N=0 -> no imem_we, load_done pulse, load_err=0.
- N=257 (bytes 0x01, 0x01) -> no writes, load_err=1, cpu_hold released; a following load_req clears load_err.
- N=2, only 5 data bytes sent, then silence for TIMEOUT cycles -> exactly one write at addr 0x0, then load_err=1.
- rx_valid held high continuously, N=1 -> rx_ready low during WRITE; exactly 6 bytes consumed; a 7th byte stays unconsumed.
- reset asserted asynchronously mid-DATA, then a fresh load_req with N=1 word 32'h0800000b -> all outputs 0 during reset; clean load writes addr 0x0 = 32'h0800000b.
